// File: rtl/rotary_entry_controller_if.sv
// Storage-port bundle between the rotary entry controller and a register or
// memory port: two-phase read and write handshakes plus shared address/data.
interface rotary_entry_controller_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
);
  logic              rdReq;
  logic              rdAck;
  logic [DATA_W-1:0] rdData;
  logic              wrReq;
  logic              wrAck;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] value;

  // Controller side: issues requests, drives address and write data.
  modport master (
    output rdReq,
    output wrReq,
    output addr,
    output value,
    input  rdAck,
    input  rdData,
    input  wrAck
  );

  // Storage side: answers requests.
  modport slave (
    input  rdReq,
    input  wrReq,
    input  addr,
    input  value,
    output rdAck,
    output rdData,
    output wrAck
  );
endinterface

// File: rtl/rotary_entry_controller.sv
// Rotary entry controller: turns debounced rotary-encoder pulses into a
// select-address / read / edit-value / write cycle on a storage port.
// All outputs come straight from registers; mode equals the FSM state code.
module rotary_entry_controller #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  right,
  input  logic                  left,
  input  logic                  down,
  output logic [1:0]            mode,
  rotary_entry_controller_if.master port
);

  typedef enum logic [1:0] {
    ST_SELECT = 2'd0,
    ST_READ   = 2'd1,
    ST_EDIT   = 2'd2,
    ST_WRITE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] value_q, value_d;
  logic              rd_req_q, rd_req_d;
  logic              wr_req_q, wr_req_d;

  // A rotation counts only when exactly one direction pulses and no press
  // arrives in the same cycle (a press takes priority over rotation).
  logic rot_up;
  logic rot_dn;
  assign rot_up = right & ~left & ~down;
  assign rot_dn = left & ~right & ~down;

  // Next-state, address/value update and request generation.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    value_d = value_q;
    unique case (state_q)
      ST_SELECT: begin
        if (down) begin
          state_d = ST_READ;
        end else if (rot_up) begin
          addr_d = addr_q + ADDR_W'(1);
        end else if (rot_dn) begin
          addr_d = addr_q - ADDR_W'(1);
        end
      end
      ST_READ: begin
        if (port.rdAck) begin
          value_d = port.rdData;
          state_d = ST_EDIT;
        end
      end
      ST_EDIT: begin
        if (down) begin
          state_d = ST_WRITE;
        end else if (rot_up) begin
          value_d = value_q + DATA_W'(1);
        end else if (rot_dn) begin
          value_d = value_q - DATA_W'(1);
        end
      end
      ST_WRITE: begin
        // Auto-advance so consecutive locations can be entered quickly.
        if (port.wrAck) begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = ST_SELECT;
        end
      end
      default: state_d = ST_SELECT;
    endcase
    // Requests are registered copies of the upcoming state, so they rise
    // with the state change and drop in the cycle after the ack.
    rd_req_d = (state_d == ST_READ);
    wr_req_d = (state_d == ST_WRITE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_SELECT;
      addr_q   <= '0;
      value_q  <= '0;
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      value_q  <= value_d;
      rd_req_q <= rd_req_d;
      wr_req_q <= wr_req_d;
    end
  end

  assign mode       = state_q;
  assign port.rdReq = rd_req_q;
  assign port.wrReq = wr_req_q;
  assign port.addr  = addr_q;
  assign port.value = value_q;

endmodule

// File: tb/tb_rotary_entry_controller.sv
// Bench for rotary_entry_controller: directed vector table, a handshake
// latency sequence, then randomized stimulus against a reference model.
module tb_rotary_entry_controller;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 4;

  logic       clk;
  logic       reset;
  logic       right;
  logic       left;
  logic       down;
  logic [1:0] mode;

  rotary_entry_controller_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  rotary_entry_controller #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .right (right),
    .left  (left),
    .down  (down),
    .mode  (mode),
    .port  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string      name;
    logic [5:0] ctl;    // {reset, right, left, down, rdAck, wrAck}
    logic [7:0] rdata;
    logic [1:0] m;
    logic [3:0] a;
    logic [7:0] val;
    logic       rq;
    logic       wq;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic [5:0] ctl, logic [7:0] rdata,
                              logic [1:0] m, logic [3:0] a, logic [7:0] val,
                              logic rq, logic wq);
    vec_t t;
    t.name = n; t.ctl = ctl; t.rdata = rdata;
    t.m = m; t.a = a; t.val = val; t.rq = rq; t.wq = wq;
    return t;
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got {mode,addr,value,rdReq,wrReq}=%h expected %h", name, got, exp);
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  function automatic logic [15:0] observed();
    return {mode, bus.addr, bus.value, bus.rdReq, bus.wrReq};
  endfunction

  // Apply one cycle of inputs, then look at the outputs just after the edge.
  task automatic step(input logic [5:0] ctl, input logic [7:0] rdata);
    {reset, right, left, down, bus.rdAck, bus.wrAck} = ctl;
    bus.rdData = rdata;
    @(posedge clk);
    #1;
  endtask

  // Reference model state (plain integers).
  int m_mode, m_addr, m_val;

  initial begin
    {reset, right, left, down, bus.rdAck, bus.wrAck} = '0;
    bus.rdData = '0;

    // ---------------- directed vector table ----------------
    vecs.push_back(mk("reset",      6'b100000, 8'h00, 2'd0, 4'd0,  8'h00, 0, 0));
    vecs.push_back(mk("sel_r1",     6'b010000, 8'h00, 2'd0, 4'd1,  8'h00, 0, 0));
    vecs.push_back(mk("sel_r2",     6'b010000, 8'h00, 2'd0, 4'd2,  8'h00, 0, 0));
    vecs.push_back(mk("sel_r3",     6'b010000, 8'h00, 2'd0, 4'd3,  8'h00, 0, 0));
    vecs.push_back(mk("sel_l1",     6'b001000, 8'h00, 2'd0, 4'd2,  8'h00, 0, 0));
    vecs.push_back(mk("sel_l2",     6'b001000, 8'h00, 2'd0, 4'd1,  8'h00, 0, 0));
    vecs.push_back(mk("sel_l3",     6'b001000, 8'h00, 2'd0, 4'd0,  8'h00, 0, 0));
    vecs.push_back(mk("sel_l4wrap", 6'b001000, 8'h00, 2'd0, 4'd15, 8'h00, 0, 0));
    vecs.push_back(mk("sel_l5",     6'b001000, 8'h00, 2'd0, 4'd14, 8'h00, 0, 0));
    vecs.push_back(mk("sel_r_a",    6'b010000, 8'h00, 2'd0, 4'd15, 8'h00, 0, 0));
    vecs.push_back(mk("sel_r_b",    6'b010000, 8'h00, 2'd0, 4'd0,  8'h00, 0, 0));
    vecs.push_back(mk("sel_r_c",    6'b010000, 8'h00, 2'd0, 4'd1,  8'h00, 0, 0));
    vecs.push_back(mk("sel_r_d",    6'b010000, 8'h00, 2'd0, 4'd2,  8'h00, 0, 0));
    vecs.push_back(mk("sel_r_e",    6'b010000, 8'h00, 2'd0, 4'd3,  8'h00, 0, 0));
    vecs.push_back(mk("sel_rl",     6'b011000, 8'h00, 2'd0, 4'd3,  8'h00, 0, 0));
    vecs.push_back(mk("sel_down",   6'b000100, 8'h00, 2'd1, 4'd3,  8'h00, 1, 0));
    vecs.push_back(mk("rd_right",   6'b010000, 8'h00, 2'd1, 4'd3,  8'h00, 1, 0));
    vecs.push_back(mk("rd_left",    6'b001000, 8'h00, 2'd1, 4'd3,  8'h00, 1, 0));
    vecs.push_back(mk("rd_dn_wack", 6'b000101, 8'h00, 2'd1, 4'd3,  8'h00, 1, 0));
    vecs.push_back(mk("rd_wait",    6'b000000, 8'h00, 2'd1, 4'd3,  8'h00, 1, 0));
    vecs.push_back(mk("rd_ack_fe",  6'b000010, 8'hFE, 2'd2, 4'd3,  8'hFE, 0, 0));
    vecs.push_back(mk("ed_r1",      6'b010000, 8'h00, 2'd2, 4'd3,  8'hFF, 0, 0));
    vecs.push_back(mk("ed_r2wrap",  6'b010000, 8'h00, 2'd2, 4'd3,  8'h00, 0, 0));
    vecs.push_back(mk("ed_r3",      6'b010000, 8'h00, 2'd2, 4'd3,  8'h01, 0, 0));
    vecs.push_back(mk("ed_down_r",  6'b010100, 8'h00, 2'd3, 4'd3,  8'h01, 0, 1));
    vecs.push_back(mk("wr_rack",    6'b000010, 8'hAA, 2'd3, 4'd3,  8'h01, 0, 1));
    vecs.push_back(mk("wr_wait",    6'b000000, 8'h00, 2'd3, 4'd3,  8'h01, 0, 1));
    vecs.push_back(mk("wr_ack",     6'b000001, 8'h00, 2'd0, 4'd4,  8'h01, 0, 0));
    vecs.push_back(mk("down_again", 6'b000100, 8'h00, 2'd1, 4'd4,  8'h01, 1, 0));
    vecs.push_back(mk("rd_ack_10",  6'b000010, 8'h10, 2'd2, 4'd4,  8'h10, 0, 0));
    vecs.push_back(mk("ed_down",    6'b000100, 8'h00, 2'd3, 4'd4,  8'h10, 0, 1));
    vecs.push_back(mk("rst_in_wr",  6'b100000, 8'h00, 2'd0, 4'd0,  8'h00, 0, 0));
    vecs.push_back(mk("late_wack",  6'b000001, 8'h00, 2'd0, 4'd0,  8'h00, 0, 0));
    vecs.push_back(mk("sel_l_wrap", 6'b001000, 8'h00, 2'd0, 4'd15, 8'h00, 0, 0));
    vecs.push_back(mk("down_15",    6'b000100, 8'h00, 2'd1, 4'd15, 8'h00, 1, 0));
    vecs.push_back(mk("rd_ack_5a",  6'b000010, 8'h5A, 2'd2, 4'd15, 8'h5A, 0, 0));
    vecs.push_back(mk("ed_left",    6'b001000, 8'h00, 2'd2, 4'd15, 8'h59, 0, 0));
    vecs.push_back(mk("ed_down15",  6'b000100, 8'h00, 2'd3, 4'd15, 8'h59, 0, 1));
    vecs.push_back(mk("wack_wrap",  6'b000001, 8'h00, 2'd0, 4'd0,  8'h59, 0, 0));
    vecs.push_back(mk("down_0",     6'b000100, 8'h00, 2'd1, 4'd0,  8'h59, 1, 0));
    vecs.push_back(mk("rst_in_rd",  6'b100010, 8'h33, 2'd0, 4'd0,  8'h00, 0, 0));
    vecs.push_back(mk("late_rack",  6'b000010, 8'h77, 2'd0, 4'd0,  8'h00, 0, 0));

    foreach (vecs[i]) begin
      step(vecs[i].ctl, vecs[i].rdata);
      check(vecs[i].name, observed(),
            {vecs[i].m, vecs[i].a, vecs[i].val, vecs[i].rq, vecs[i].wq});
    end

    // ---------------- read-request duration for several ack delays ----------------
    for (int k = 0; k < 7; k += 3) begin
      int cnt;
      step(6'b100000, 8'h00);
      step(6'b000100, 8'h00);
      cnt = 0;
      for (int i = 0; i < 50 && bus.rdReq; i++) begin
        cnt++;
        step((cnt == k + 1) ? 6'b000010 : 6'b000000, 8'hC3);
      end
      check_int($sformatf("rdreq_len_k%0d", k), cnt, k + 1);
      check($sformatf("after_rd_k%0d", k), observed(), {2'd2, 4'd0, 8'hC3, 1'b0, 1'b0});
    end

    // ---------------- randomized stimulus vs reference model ----------------
    step(6'b100000, 8'h00);
    m_mode = 0; m_addr = 0; m_val = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic       r_rst, r_r, r_l, r_d, r_ra, r_wa;
      logic [7:0] r_data;
      logic [15:0] exp;
      int m_val_bits, m_addr_bits, m_mode_bits;
      r_rst  = ($urandom_range(0, 99) == 0);
      r_r    = ($urandom_range(0, 3) == 0);
      r_l    = ($urandom_range(0, 3) == 0);
      r_d    = ($urandom_range(0, 5) == 0);
      r_ra   = ($urandom_range(0, 2) == 0);
      r_wa   = ($urandom_range(0, 2) == 0);
      r_data = 8'($urandom);
      step({r_rst, r_r, r_l, r_d, r_ra, r_wa}, r_data);

      if (r_rst) begin
        m_mode = 0; m_addr = 0; m_val = 0;
      end else if (m_mode == 0) begin
        if (r_d) m_mode = 1;
        else if (r_r && !r_l) m_addr = (m_addr + 1) % 16;
        else if (r_l && !r_r) m_addr = (m_addr + 15) % 16;
      end else if (m_mode == 1) begin
        if (r_ra) begin m_val = int'(r_data); m_mode = 2; end
      end else if (m_mode == 2) begin
        if (r_d) m_mode = 3;
        else if (r_r && !r_l) m_val = (m_val + 1) % 256;
        else if (r_l && !r_r) m_val = (m_val + 255) % 256;
      end else begin
        if (r_wa) begin m_addr = (m_addr + 1) % 16; m_mode = 0; end
      end

      m_mode_bits = m_mode; m_addr_bits = m_addr; m_val_bits = m_val;
      exp = {m_mode_bits[1:0], m_addr_bits[3:0], m_val_bits[7:0],
             (m_mode == 1), (m_mode == 3)};
      check($sformatf("rand_c%0d", cyc), observed(), exp);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
